// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default oversampling rate and receiver states.
// Used by uart_receiver (parity build selected by UART_RX_PARITY_EN) and the transmitter.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS   = 8;
   localparam int unsigned UART_OS_RATE_DEF = 16;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// SYNC_STAGES-deep flop synchronizer for an asynchronous level; resets to 1 (idle line).
module uart_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stages <= '1;
      else
         stages <= {stages[SYNC_STAGES-2:0], d};
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on an oversampling tick.
// Define UART_RX_PARITY_EN to add an even-parity bit after D7 and drive parity_err.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned OS_RATE     = UART_OS_RATE_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      os_tick,
   input  logic                      rx_serial,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      rx_busy,
   output logic                      frame_err,
   output logic                      parity_err
);

   localparam int unsigned TW = $clog2(OS_RATE);
   localparam logic [TW-1:0] HALF_M1 = TW'(OS_RATE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OS_RATE - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = RX_IDLE;
   localparam logic [2:0] S_START  = RX_START;
   localparam logic [2:0] S_DATA   = RX_DATA;
   localparam logic [2:0] S_STOP   = RX_STOP;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = RX_PARITY;
`endif

   if (OS_RATE < 4 || (OS_RATE % 2) != 0) begin : g_bad_os_rate
      $error("uart_receiver: OS_RATE must be even and >= 4");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_receiver: SYNC_STAGES must be >= 2");
   end

   logic                      rx_s;
   logic [2:0]                state;
   logic [TW-1:0]             tick_cnt;
   logic [2:0]                bit_cnt;
   logic                      armed;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      at_mid;

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_serial),
      .q   (rx_s)
   );

   // Explicit wrap keeps the counter correct for non-power-of-two OS_RATE.
   always_comb begin
      at_mid = (tick_cnt == FULL_M1);
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         armed     <= 1'b0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (os_tick) begin
            case (state)
               S_IDLE: begin
                  // A held-low line never re-arms, so a break yields no frames.
                  if (rx_s) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     tick_cnt <= '0;
                     armed    <= 1'b0;
                     rx_busy  <= 1'b1;
                     state    <= S_START;
                  end
               end
               S_START: begin
                  if (tick_cnt == HALF_M1) begin
                     if (rx_s) begin
                        rx_busy <= 1'b0;
                        state   <= S_IDLE;
                     end else begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad  <= 1'b0;
`endif
                        state    <= S_DATA;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (at_mid) begin
                     tick_cnt       <= '0;
                     shreg[bit_cnt] <= rx_s;
                     bit_cnt        <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (at_mid) begin
                     tick_cnt <= '0;
                     par_bad  <= ^{shreg, rx_s};
                     state    <= S_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`endif
               S_STOP: begin
                  if (at_mid) begin
                     tick_cnt  <= '0;
                     rx_busy   <= 1'b0;
                     armed     <= 1'b0;
                     state     <= S_IDLE;
                     frame_err <= ~rx_s;
                     if (rx_s) begin
                        rx_data <= shreg;
                     end
`ifdef UART_RX_PARITY_EN
                     rx_valid   <= rx_s & ~par_bad;
                     parity_err <= par_bad;
`else
                     rx_valid   <= rx_s;
`endif
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: begin
                  rx_busy <= 1'b0;
                  state   <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level model of expected strobes and held data.
// Covers the UART_RX_PARITY_EN build when that macro is defined for both bench and RTL.
module tb_uart_receiver;

   localparam int unsigned OS      = 16;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned BIT_CLK = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   // Stop-bit midpoint measured from the start edge: 9.5 (or 10.5) bit periods.
   localparam int unsigned LAT = PAR ? (BIT_CLK * 21) / 2 : (BIT_CLK * 19) / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       os_tick;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned n_valid = 0;
   int unsigned n_ferr = 0;
   int unsigned n_perr = 0;
   logic [7:0]  model_data = 8'h00;

   typedef struct {
      logic        v;
      logic        fe;
      logic        pe;
      logic [7:0]  d;
      int unsigned t0;
   } exp_t;

   exp_t exp_q[$];
   exp_t ce;

   uart_receiver #(.OS_RATE(OS), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .os_tick    (os_tick),
      .rx_serial  (rx_serial),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      int unsigned tc;
      tc = 0;
      os_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tc = (tc + 1) % TICK_DIV;
         os_tick = (tc == 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare process: every strobe must match the oldest expected frame outcome.
   always @(negedge clk) begin
      if (rx_valid || frame_err || parity_err) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: valid=%b ferr=%b perr=%b with no frame pending",
                     rx_valid, frame_err, parity_err);
         end else begin
            ce = exp_q.pop_front();
            chk("strobe_valid", {31'b0, rx_valid}, {31'b0, ce.v});
            chk("strobe_ferr", {31'b0, frame_err}, {31'b0, ce.fe});
            chk("strobe_perr", {31'b0, parity_err}, {31'b0, ce.pe});
            chk("strobe_timing",
                {31'b0, (cyc >= ce.t0 + LAT - 8) && (cyc <= ce.t0 + LAT + 17)}, 32'd1);
            if (!ce.fe) model_data = ce.d;
         end
         if (rx_valid) n_valid++;
         if (frame_err) n_ferr++;
         if (parity_err) n_perr++;
      end
      chk("rx_data", {24'b0, rx_data}, {24'b0, model_data});
   end

   task automatic drive_bit(input logic b);
      rx_serial = b;
      repeat (BIT_CLK) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned bits);
      rx_serial = 1'b1;
      repeat (bits * BIT_CLK) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      exp_t e;
      logic pbad;
      pbad = PAR && ((^d) ^ par_b);
      e.v  = stop_b && !pbad;
      e.fe = !stop_b;
      e.pe = pbad;
      e.d  = d;
      e.t0 = cyc;
      exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) chk("busy_mid_frame", {31'b0, rx_busy}, 32'd1);
         drive_bit(d[i]);
      end
      if (PAR) drive_bit(par_b);
      drive_bit(stop_b);
   endtask

   task automatic drain;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("no_missing_strobe", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] v;
      rst = 1'b1;
      rx_serial = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("reset_rx_data", {24'b0, rx_data}, 32'h00);
      chk("reset_busy", {31'b0, rx_busy}, 32'd0);
      chk("reset_valid", {31'b0, rx_valid}, 32'd0);
      chk("reset_ferr", {31'b0, frame_err}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Good byte
      send_frame(8'hA5, 1'b1, 1'b0);
      drain();
      chk("good_byte_data", {24'b0, rx_data}, 32'hA5);
      chk("good_byte_busy_after", {31'b0, rx_busy}, 32'd0);
      idle(1);

      // Framing error keeps previous data
      send_frame(8'h3C, 1'b0, 1'b0);
      drain();
      idle(2);
      chk("ferr_data_kept", {24'b0, rx_data}, 32'hA5);
      chk("ferr_count", n_ferr, 32'd1);

      // Glitch of 3 ticks while idle
      rx_serial = 1'b0;
      repeat (3 * TICK_DIV) @(posedge clk);
      #1;
      rx_serial = 1'b1;
      repeat (20 * TICK_DIV) @(posedge clk);
      #1;
      chk("glitch_busy", {31'b0, rx_busy}, 32'd0);
      chk("glitch_data", {24'b0, rx_data}, 32'hA5);
      idle(1);

      // Back-to-back frames, no idle gap
      v = 8'h00;
      send_frame(v, 1'b1, ^v);
      v = 8'hFF;
      send_frame(v, 1'b1, ^v);
      v = 8'h55;
      send_frame(v, 1'b1, ^v);
      rx_serial = 1'b1;
      drain();
      chk("b2b_last_data", {24'b0, rx_data}, 32'h55);
      chk("b2b_valid_count", n_valid, 32'd4);
      idle(1);

      // Reset after data bit 4
      drive_bit(1'b0);
      v = 8'h3C;
      for (int i = 0; i < 5; i++) drive_bit(v[i]);
      chk("busy_before_reset", {31'b0, rx_busy}, 32'd1);
      rst = 1'b1;
      model_data = 8'h00;
      #1;
      chk("midreset_data", {24'b0, rx_data}, 32'h00);
      chk("midreset_busy", {31'b0, rx_busy}, 32'd0);
      chk("midreset_valid", {31'b0, rx_valid}, 32'd0);
      chk("midreset_ferr", {31'b0, frame_err}, 32'd0);
      chk("midreset_perr", {31'b0, parity_err}, 32'd0);
      rx_serial = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      v = 8'h81;
      send_frame(v, 1'b1, ^v);
      drain();
      chk("after_reset_data", {24'b0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
      idle(1);
      send_frame(8'h07, 1'b1, 1'b1);
      drain();
      chk("parity_ok_data", {24'b0, rx_data}, 32'h07);
      idle(1);
      send_frame(8'h07, 1'b1, 1'b0);
      drain();
      chk("parity_err_count", n_perr, 32'd1);
      chk("total_valid", n_valid, 32'd6);
`else
      chk("parity_err_count", n_perr, 32'd0);
      chk("total_valid", n_valid, 32'd5);
`endif
      idle(2);
      chk("final_ferr_count", n_ferr, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
